// File: rtl/second_int_pkg.sv
`default_nettype none
// ============================================================================
// second_int_pkg : shared types, defaults and clamp-bound helpers
// Rev 1.0
// ============================================================================
package second_int_pkg;

    localparam int DEF_IN_W  = 13;
    localparam int DEF_OUT_W = 16;

    typedef enum logic [2:0] {
        S_WAIT   = 3'b001,
        S_CALC   = 3'b010,
        S_FINISH = 3'b100
    } state_t;

    function automatic longint sat_hi(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/second_int_if.sv
`default_nettype none
// ============================================================================
// second_int_if : enable/finish handshake bus of the second-order integrator
// Rev 1.0
// ============================================================================
interface second_int_if #(
    parameter int IN_W  = 13,
    parameter int OUT_W = 16
) ();

    logic                    clr;
    logic                    en_second_int;
    logic signed [IN_W-1:0]  dif_data;
    logic signed [OUT_W-1:0] int_data;
    logic                    int_finish;
    logic                    sat_flag;

    modport master (
        output clr,
        output en_second_int,
        output dif_data,
        input  int_data,
        input  int_finish,
        input  sat_flag
    );

    modport slave (
        input  clr,
        input  en_second_int,
        input  dif_data,
        output int_data,
        output int_finish,
        output sat_flag
    );

endinterface
`default_nettype wire

// File: rtl/second_int_sat.sv
`default_nettype none
// ============================================================================
// second_int_sat : combinational saturating narrowing clamp with overflow flag
// Rev 1.0
// ============================================================================
module second_int_sat
    import second_int_pkg::*;
#(
    parameter int IN_W  = 19,
    parameter int OUT_W = 16
) (
    input  wire logic signed [IN_W-1:0]  value,
    output logic signed [OUT_W-1:0]      clamped,
    output logic                         ovf
);

    localparam logic signed [OUT_W-1:0] c_hi = OUT_W'(sat_hi(OUT_W));
    localparam logic signed [OUT_W-1:0] c_lo = OUT_W'(sat_lo(OUT_W));

    logic [IN_W-OUT_W:0] w_top;

    // The value fits iff every bit above the output sign bit equals it.
    always_comb begin
        w_top   = value[IN_W-1:OUT_W-1];
        ovf     = !((&w_top) || (~|w_top));
        clamped = value[OUT_W-1:0];
        if (ovf) begin
            clamped = value[IN_W-1] ? c_lo : c_hi;
        end
    end

endmodule
`default_nettype wire

// File: rtl/second_int.sv
`default_nettype none
// ============================================================================
// second_int : second-order integrator, y[n] = 2*y[n-1] - y[n-2] + d[n]
// Rev 1.0
// ============================================================================
module second_int
    import second_int_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    second_int_if.slave bus
);

    localparam int W = OUT_W + 3;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_load;
    logic signed [OUT_W-1:0] r_y1;
    logic signed [OUT_W-1:0] r_y2;
    logic signed [OUT_W-1:0] r_data;
    logic                    r_finish;
    logic                    r_sat;
    logic signed [W-1:0]     w_v;
    logic signed [OUT_W-1:0] w_v_sat;
    logic                    w_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
        end else if (bus.clr) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_WAIT;
        w_load      = 1'b0;
        case (r_state)
            S_WAIT:   w_state_nxt = bus.en_second_int ? S_CALC : S_WAIT;
            S_CALC: begin
                w_load      = 1'b1;
                w_state_nxt = S_FINISH;
            end
            S_FINISH: w_state_nxt = S_WAIT;
            default:  w_state_nxt = S_WAIT;
        endcase
    end

    // Three guard bits cover 2*y1 - y2 + d without wrap before the clamp.
    assign w_v = ({{3{r_y1[OUT_W-1]}}, r_y1} <<< 1)
               - {{3{r_y2[OUT_W-1]}}, r_y2}
               + {{(W-IN_W){bus.dif_data[IN_W-1]}}, bus.dif_data};

    second_int_sat #(
        .IN_W  (W),
        .OUT_W (OUT_W)
    ) u_sat (
        .value   (w_v),
        .clamped (w_v_sat),
        .ovf     (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clr) begin
            r_y1     <= '0;
            r_y2     <= '0;
            r_data   <= '0;
            r_finish <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            r_finish <= w_load;
            if (w_load) begin
                r_data <= w_v_sat;
                r_y2   <= r_y1;
                r_y1   <= w_v_sat;
                if (w_ovf) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign bus.int_data   = r_data;
    assign bus.int_finish = r_finish;
    assign bus.sat_flag   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_second_int.sv
`default_nettype none
// ============================================================================
// tb_second_int : scoreboard bench for the second-order integrator
// Rev 1.0
// ============================================================================
module tb_second_int;

    localparam int IN_W  = 13;
    localparam int OUT_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    second_int_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    second_int #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        longint data;
        longint sat;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    int     n_fin    = 0;
    longint m_y1     = 0;
    longint m_y2     = 0;
    longint m_sat    = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void model_push(input longint d);
        longint v;
        longint hi;
        longint lo;
        exp_t   e;
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -(longint'(1) <<< (OUT_W - 1));
        v  = 2 * m_y1 - m_y2 + d;
        if (v > hi) begin
            v = hi; m_sat = 1;
        end else if (v < lo) begin
            v = lo; m_sat = 1;
        end
        m_y2   = m_y1;
        m_y1   = v;
        e.data = v;
        e.sat  = m_sat;
        sb.push_back(e);
    endfunction

    function automatic void model_clear();
        m_y1  = 0;
        m_y2  = 0;
        m_sat = 0;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus.int_finish) begin
            n_fin++;
            if (sb.size() == 0) begin
                check("unexpected_finish", 1, 0);
            end else begin
                e = sb.pop_front();
                check("int_data", bus.int_data, e.data);
                check("sat_flag", longint'(bus.sat_flag), e.sat);
            end
        end
    end

    task automatic step(input longint d);
        model_push(d);
        @(negedge clk);
        bus.en_second_int = 1'b1;
        bus.dif_data      = IN_W'(d);
        @(negedge clk);
        bus.en_second_int = 1'b0;
        check("fin_low_in_calc", longint'(bus.int_finish), 0);
        @(negedge clk);
        check("fin_high_after_capture", longint'(bus.int_finish), 1);
        @(negedge clk);
        check("fin_one_cycle", longint'(bus.int_finish), 0);
    endtask

    task automatic do_clr();
        @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        model_clear();
        check("clr_data", bus.int_data, 0);
        check("clr_sat", longint'(bus.sat_flag), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int fin0;
        int ramp[4]  = '{5, 0, 0, 0};
        int round[4] = '{0, 3, 1, 1};

        bus.clr           = 1'b0;
        bus.en_second_int = 1'b1;
        bus.dif_data      = 13'sd100;
        rst_n             = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", bus.int_data, 0);
        check("rst_finish", longint'(bus.int_finish), 0);
        check("rst_sat", longint'(bus.sat_flag), 0);
        @(negedge clk);
        bus.en_second_int = 1'b0;
        rst_n             = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_no_activity", n_fin, 0);

        foreach (ramp[i]) step(ramp[i]);

        do_clr();
        foreach (round[i]) step(round[i]);

        do_clr();
        repeat (5) step(4095);

        // en held high: one step every three cycles
        fin0 = n_fin;
        repeat (4) model_push(2);
        @(negedge clk);
        bus.en_second_int = 1'b1;
        bus.dif_data      = 13'sd2;
        repeat (12) @(negedge clk);
        bus.en_second_int = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("en_held_steps", n_fin - fin0, 4);

        // en still high through CALC and FINISH yields one step
        fin0 = n_fin;
        model_push(-4);
        @(negedge clk);
        bus.en_second_int = 1'b1;
        bus.dif_data      = -13'sd4;
        repeat (3) @(negedge clk);
        bus.en_second_int = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("en_extra_pulses", n_fin - fin0, 1);

        // clr colliding with en
        fin0 = n_fin;
        @(negedge clk);
        bus.clr           = 1'b1;
        bus.en_second_int = 1'b1;
        bus.dif_data      = 13'sd50;
        @(negedge clk);
        bus.clr           = 1'b0;
        bus.en_second_int = 1'b0;
        model_clear();
        check("clr_en_data", bus.int_data, 0);
        check("clr_en_sat", longint'(bus.sat_flag), 0);
        repeat (3) @(negedge clk);
        #1;
        check("clr_en_no_finish", n_fin - fin0, 0);

        // clr during CALC aborts the step
        @(negedge clk);
        bus.en_second_int = 1'b1;
        bus.dif_data      = 13'sd9;
        @(negedge clk);
        bus.en_second_int = 1'b0;
        bus.clr           = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("clr_calc_no_finish", n_fin - fin0, 0);
        check("clr_calc_data", bus.int_data, 0);

        step(7);

        repeat (3) @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
